// File: rtl/cpu_regfile_wb_ctrl.sv
// cpu_regfile_wb_ctrl: write-back arbiter and pending-write scoreboard for a 16-entry byte-enabled register file
//   clk, rst                      clock, async active-high reset
//   iss_*  / rd0_addr_i, rd1_addr_i  destination claim (WAW stall) and source hazard query
//   alu_*                         unbuffered full-word ALU write-back request
//   lsu_*                         byte-enabled LSU write-back, buffered in an LSU_FIFO_DEPTH FIFO
//   wr_addr_o, byte_en_o, wr_data_o  registered register-file write port (byte_en_o=0: no write)
//   pending_o                     outstanding-write scoreboard
//   wb_err_o                      sticky orphan/collision flag, present only with CPU_WB_ERRCHK_EN
module cpu_regfile_wb_ctrl #(
    parameter int LSU_FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iss_valid_i,
    input  logic [3:0]  iss_addr_i,
    output logic        iss_ready_o,
    input  logic [3:0]  rd0_addr_i,
    input  logic [3:0]  rd1_addr_i,
    output logic        rd_hazard_o,
    input  logic        alu_valid_i,
    output logic        alu_ready_o,
    input  logic [3:0]  alu_addr_i,
    input  logic [31:0] alu_data_i,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [3:0]  lsu_addr_i,
    input  logic [3:0]  lsu_byte_en_i,
    input  logic [31:0] lsu_data_i,
    output logic [3:0]  wr_addr_o,
    output logic [3:0]  byte_en_o,
    output logic [31:0] wr_data_o,
    output logic [15:0] pending_o
`ifdef CPU_WB_ERRCHK_EN
    ,
    output logic        wb_err_o
`endif
);
    localparam int AW = (LSU_FIFO_DEPTH > 1) ? $clog2(LSU_FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW + 1)'(LSU_FIFO_DEPTH);

    typedef struct packed {
        logic [3:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
    } lsu_ent_t;

    lsu_ent_t      mem_q [LSU_FIFO_DEPTH];
    lsu_ent_t      head;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          lsu_pri_q, lsu_pri_d;
    logic [3:0]    wr_addr_q, wr_addr_d, be_q, be_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic          commit_q, commit_d;
    logic [15:0]   pend_q, pend_d;
    logic          push, lsu_avail, gnt_alu, gnt_lsu;

    assign lsu_ready_o = cnt_q != FULL;
    assign iss_ready_o = !pend_q[iss_addr_i];
    assign rd_hazard_o = pend_q[rd0_addr_i] | pend_q[rd1_addr_i];
    assign alu_ready_o = gnt_alu;
    assign wr_addr_o   = wr_addr_q;
    assign byte_en_o   = be_q;
    assign wr_data_o   = wr_data_q;
    assign pending_o   = pend_q;

    always_comb begin
        head      = mem_q[rd_ptr_q];
        lsu_avail = cnt_q != '0;
        // lsu_pri_q is set after an ALU grant, so the path not granted last wins a tie
        gnt_alu   = alu_valid_i && (!lsu_avail || !lsu_pri_q);
        gnt_lsu   = lsu_avail && !gnt_alu;
        push      = lsu_valid_i && lsu_ready_o;
        rd_ptr_d  = gnt_lsu ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        cnt_d     = cnt_q + (AW + 1)'(push) - (AW + 1)'(gnt_lsu);
        lsu_pri_d = (gnt_alu || gnt_lsu) ? gnt_alu : lsu_pri_q;
        wr_addr_d = gnt_alu ? alu_addr_i : gnt_lsu ? head.addr : wr_addr_q;
        wr_data_d = gnt_alu ? alu_data_i : gnt_lsu ? head.data : wr_data_q;
        be_d      = gnt_alu ? 4'hF : gnt_lsu ? head.be : 4'h0;
        // commit_q also covers zero-enable LSU entries, which retire without writing
        commit_d  = gnt_alu || gnt_lsu;
        // clear first so a claim landing on the commit edge keeps the bit set
        pend_d    = (pend_q & ~(commit_q ? (16'h1 << wr_addr_q) : 16'h0))
                  | ((iss_valid_i && iss_ready_o) ? (16'h1 << iss_addr_i) : 16'h0);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {lsu_addr_i, lsu_byte_en_i, lsu_data_i};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            lsu_pri_q <= 1'b0;
            wr_addr_q <= 4'h0;
            wr_data_q <= 32'h0;
            be_q      <= 4'h0;
            commit_q  <= 1'b0;
            pend_q    <= 16'h0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            lsu_pri_q <= lsu_pri_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            be_q      <= be_d;
            commit_q  <= commit_d;
            pend_q    <= pend_d;
        end
    end

`ifdef CPU_WB_ERRCHK_EN
    logic err_q, err_d;

    assign wb_err_o = err_q;

    always_comb begin
        err_d = err_q | (commit_q && !pend_q[wr_addr_q])
              | (alu_valid_i && lsu_valid_i && alu_addr_i == lsu_addr_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
`endif
endmodule

// File: tb/tb_cpu_regfile_wb_ctrl.sv
// tb_cpu_regfile_wb_ctrl: directed scenarios plus randomized traffic checked against a queue-based reference model
module tb_cpu_regfile_wb_ctrl;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iss_valid_i = 1'b0;
    logic [3:0]  iss_addr_i = 4'h0;
    logic        iss_ready_o;
    logic [3:0]  rd0_addr_i = 4'h0;
    logic [3:0]  rd1_addr_i = 4'h0;
    logic        rd_hazard_o;
    logic        alu_valid_i = 1'b0;
    logic        alu_ready_o;
    logic [3:0]  alu_addr_i = 4'h0;
    logic [31:0] alu_data_i = 32'h0;
    logic        lsu_valid_i = 1'b0;
    logic        lsu_ready_o;
    logic [3:0]  lsu_addr_i = 4'h0;
    logic [3:0]  lsu_byte_en_i = 4'h0;
    logic [31:0] lsu_data_i = 32'h0;
    logic [3:0]  wr_addr_o;
    logic [3:0]  byte_en_o;
    logic [31:0] wr_data_o;
    logic [15:0] pending_o;
`ifdef CPU_WB_ERRCHK_EN
    logic        wb_err_o;
`endif

    cpu_regfile_wb_ctrl #(.LSU_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .iss_valid_i(iss_valid_i), .iss_addr_i(iss_addr_i), .iss_ready_o(iss_ready_o),
        .rd0_addr_i(rd0_addr_i), .rd1_addr_i(rd1_addr_i), .rd_hazard_o(rd_hazard_o),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_addr_i(alu_addr_i), .alu_data_i(alu_data_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_addr_i(lsu_addr_i),
        .lsu_byte_en_i(lsu_byte_en_i), .lsu_data_i(lsu_data_i),
        .wr_addr_o(wr_addr_o), .byte_en_o(byte_en_o), .wr_data_o(wr_data_o), .pending_o(pending_o)
`ifdef CPU_WB_ERRCHK_EN
        , .wb_err_o(wb_err_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  a;
        logic [3:0]  be;
        logic [31:0] d;
    } ent_t;

    int          n_chk = 0;
    int          n_err = 0;
    ent_t        fq[$];
    logic [15:0] m_pend;
    logic        m_last_lsu;
    logic [3:0]  m_addr, m_be;
    logic [31:0] m_data;
    logic        m_commit;
    logic        m_err;
    logic        alu_wait;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        m_pend = 16'h0;
        m_last_lsu = 1'b1;
        m_addr = 4'h0;
        m_be = 4'h0;
        m_data = 32'h0;
        m_commit = 1'b0;
        m_err = 1'b0;
        alu_wait = 1'b0;
    endtask

    task automatic idle();
        iss_valid_i = 1'b0;
        alu_valid_i = 1'b0;
        lsu_valid_i = 1'b0;
        rd0_addr_i = 4'h0;
        rd1_addr_i = 4'h0;
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs after the edge.
    task automatic step();
        logic ga, gl, iss_ok, room;
        ent_t e;
        #1;
        room   = fq.size() < DEPTH;
        ga     = alu_valid_i && (fq.size() == 0 || m_last_lsu);
        gl     = fq.size() != 0 && !ga;
        iss_ok = !m_pend[iss_addr_i];
        chk("iss_ready", iss_ready_o, iss_ok);
        chk("rd_hazard", rd_hazard_o, m_pend[rd0_addr_i] | m_pend[rd1_addr_i]);
        chk("alu_ready", alu_ready_o, ga);
        chk("lsu_ready", lsu_ready_o, room);
        if (m_commit && !m_pend[m_addr]) m_err = 1'b1;
        if (alu_valid_i && lsu_valid_i && alu_addr_i == lsu_addr_i) m_err = 1'b1;
        if (m_commit) m_pend[m_addr] = 1'b0;
        if (iss_valid_i && iss_ok) m_pend[iss_addr_i] = 1'b1;
        m_commit = ga || gl;
        if (ga) begin
            m_addr = alu_addr_i;
            m_be = 4'hF;
            m_data = alu_data_i;
            m_last_lsu = 1'b0;
        end else if (gl) begin
            e = fq.pop_front();
            m_addr = e.a;
            m_be = e.be;
            m_data = e.d;
            m_last_lsu = 1'b1;
        end else m_be = 4'h0;
        if (lsu_valid_i && room) fq.push_back('{lsu_addr_i, lsu_byte_en_i, lsu_data_i});
        alu_wait = alu_valid_i && !ga;
        @(posedge clk);
        #1;
        chk("wr_addr", wr_addr_o, m_addr);
        chk("byte_en", byte_en_o, m_be);
        chk("wr_data", wr_data_o, m_data);
        chk("pending", pending_o, m_pend);
`ifdef CPU_WB_ERRCHK_EN
        chk("wb_err", wb_err_o, m_err);
`endif
        @(negedge clk);
    endtask

    task automatic hard_reset();
        idle();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_byte_en", byte_en_o, 4'h0);
        chk("rst_pending", pending_o, 16'h0);
        chk("rst_lsu_ready", lsu_ready_o, 1'b1);
        rst = 1'b0;

        // claim r5, ALU writes it, hazard clears after the commit edge
        iss_valid_i = 1'b1; iss_addr_i = 4'd5; rd0_addr_i = 4'd5;
        step();
        iss_valid_i = 1'b0;
        alu_valid_i = 1'b1; alu_addr_i = 4'd5; alu_data_i = 32'hDEADBEEF;
        step();
        chk("r5_be", byte_en_o, 4'hF);
        chk("r5_addr", wr_addr_o, 4'd5);
        chk("r5_hz_set", rd_hazard_o, 1'b1);
        alu_valid_i = 1'b0;
        step();
        chk("r5_pend_clr", pending_o[5], 1'b0);
        chk("r5_hz_clr", rd_hazard_o, 1'b0);

        // ALU r1 and LSU r2 together: grants alternate
        alu_valid_i = 1'b1; alu_addr_i = 4'd1; alu_data_i = 32'h11111111;
        lsu_valid_i = 1'b1; lsu_addr_i = 4'd2; lsu_byte_en_i = 4'h3; lsu_data_i = 32'h0000BEEF;
        step(); chk("alt0_be", byte_en_o, 4'hF);
        step(); chk("alt1_be", byte_en_o, 4'h3);
        step(); chk("alt2_be", byte_en_o, 4'hF);
        step(); chk("alt3_be", byte_en_o, 4'h3);
        idle();
        repeat (3) step();

        // claim r7 twice; re-claim succeeds only after the commit is visible
        iss_valid_i = 1'b1; iss_addr_i = 4'd7;
        step();
        step();
        chk("r7_waw", iss_ready_o, 1'b0);
        alu_valid_i = 1'b1; alu_addr_i = 4'd7; alu_data_i = 32'h77;
        step();
        alu_valid_i = 1'b0;
        step();
        step();
        chk("r7_reclaim", pending_o[7], 1'b1);
        idle();
        step();

        // fill the FIFO with the ALU busy, then reset asynchronously mid-cycle
        hard_reset();
        alu_valid_i = 1'b1; alu_addr_i = 4'd1; alu_data_i = 32'hA1;
        lsu_valid_i = 1'b1; lsu_addr_i = 4'd2; lsu_byte_en_i = 4'h5; lsu_data_i = 32'hB2;
        repeat (3) step();
        idle();
        chk("full_ready", lsu_ready_o, 1'b0);
        chk("full_be", byte_en_o, 4'hF);
        #2 rst = 1'b1;
        #1;
        chk("arst_be", byte_en_o, 4'h0);
        chk("arst_addr", wr_addr_o, 4'h0);
        chk("arst_data", wr_data_o, 32'h0);
        chk("arst_pending", pending_o, 16'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1 chk("arst_ready", lsu_ready_o, 1'b1);
        @(negedge clk);
        step();

`ifdef CPU_WB_ERRCHK_EN
        // orphan write to r9 sets the sticky error
        hard_reset();
        alu_valid_i = 1'b1; alu_addr_i = 4'd9; alu_data_i = 32'h99;
        step();
        alu_valid_i = 1'b0;
        step();
        chk("orphan_err", wb_err_o, 1'b1);
        repeat (3) step();
        chk("orphan_sticky", wb_err_o, 1'b1);
        hard_reset();
`endif

        // randomized traffic; ALU holds its request until granted
        for (int c = 0; c < 400; c++) begin
            iss_valid_i = 1'($urandom);
            iss_addr_i = 4'($urandom);
            rd0_addr_i = 4'($urandom);
            rd1_addr_i = 4'($urandom);
            if (!alu_wait) begin
                alu_valid_i = ($urandom % 3) != 0;
                alu_addr_i = 4'($urandom);
                alu_data_i = $urandom;
            end
            lsu_valid_i = 1'($urandom);
            lsu_addr_i = 4'($urandom);
            lsu_byte_en_i = 4'($urandom);
            lsu_data_i = $urandom;
            step();
            if (c == 200) hard_reset();
        end
        idle();
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
